// File: rtl/priority_arbiter_8_if.sv
// rtl/priority_arbiter_8_if.sv - request/grant bundle for priority_arbiter_8
//
// Purpose: groups the arbiter request inputs and registered grant outputs.
// Signals:
//   arb_en    : 1  requester side -> arbiter, allows new grants
//   req       : 8  requester side -> arbiter, req[7] highest priority
//   gnt       : 8  arbiter -> requester side, one-hot grant
//   gnt_id    : 3  arbiter -> requester side, binary index of the grant
//   gnt_valid : 1  arbiter -> requester side, high while gnt != 0
//   timeout   : 1  arbiter -> requester side, one-cycle forced-release pulse
// Modports: master (requester side), slave (arbiter).
interface priority_arbiter_8_if;
  logic       arb_en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output arb_en,
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  arb_en,
    input  req,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/priority_arbiter_8.sv
// rtl/priority_arbiter_8.sv - 8-way fixed-priority non-preemptive arbiter
//
// Purpose: IDLE/GRANT/RELEASE arbiter; req[7] wins over lower indices, a
// grant is held until its request drops, then one idle RELEASE cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : priority_arbiter_8_if.slave (arb_en, req in; gnt, gnt_id,
//           gnt_valid, timeout out, all outputs registered)
// Parameter: MAX_HOLD (2..256) hold limit in cycles, watchdog builds only.
// Macro: ARB_TIMEOUT_EN compiles in the hold-limit watchdog and eviction
// mask; without it grants are held indefinitely and timeout is tied 0.
module priority_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic                clk,
  input logic                rst_n,
  priority_arbiter_8_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_GRANT   = 2'b01;
  localparam logic [1:0] ST_RELEASE = 2'b10;

  logic [1:0] r_state;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_id;
  logic       r_gnt_valid;

  logic [7:0] w_cand;
  logic [2:0] w_win_id;
  logic       w_hold;
  logic       w_expire;
  logic       w_decide;

  // Highest set bit wins: later (higher) indices overwrite earlier ones.
  function automatic logic [2:0] f_prio_enc(input logic [7:0] v);
    logic [2:0] id;
    id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) id = 3'(i);
    end
    return id;
  endfunction

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt;
  logic [7:0] r_mask;
  logic       r_timeout;
  logic [7:0] w_unmasked;

  // The evicted requester is skipped only if someone else is asking;
  // a lone masked requester is still served.
  assign w_unmasked = bus.req & ~r_mask;
  assign w_cand     = (w_unmasked != 8'h00) ? w_unmasked : bus.req;
  assign w_expire   = (r_hold_cnt == 8'(MAX_HOLD - 1));
`else
  assign w_cand     = bus.req;
  assign w_expire   = 1'b0;
`endif

  assign w_win_id = f_prio_enc(w_cand);
  assign w_hold   = bus.req[r_gnt_id];
  assign w_decide = bus.arb_en && (bus.req != 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= 8'h00;
      r_gnt_id    <= 3'd0;
      r_gnt_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_decide) begin
            r_state     <= ST_GRANT;
            r_gnt       <= 8'b1 << w_win_id;
            r_gnt_id    <= w_win_id;
            r_gnt_valid <= 1'b1;
          end
        end
        ST_GRANT: begin
          // arb_en is deliberately ignored here; only the owner's request
          // (or the watchdog) ends the grant.
          if (!w_hold || w_expire) begin
            r_state     <= ST_RELEASE;
            r_gnt       <= 8'h00;
            r_gnt_id    <= 3'd0;
            r_gnt_valid <= 1'b0;
          end
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_gnt       <= 8'h00;
          r_gnt_id    <= 3'd0;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= 8'h00;
      r_mask     <= 8'h00;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_decide) begin
            r_hold_cnt <= 8'h00;
            r_mask     <= 8'h00;
          end
        end
        ST_GRANT: begin
          r_hold_cnt <= r_hold_cnt + 8'd1;
          // Forced release only when the owner still wants the bus;
          // a natural drop on the same edge is a normal release.
          if (w_hold && w_expire) begin
            r_timeout <= 1'b1;
            r_mask    <= r_gnt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_priority_arbiter_8.sv
// tb/tb_priority_arbiter_8.sv - directed table-driven bench for priority_arbiter_8
module tb_priority_arbiter_8;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       tmo;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[$];

  priority_arbiter_8_if bus ();

  priority_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic add(input logic en, input logic [7:0] req, input logic [7:0] gnt,
                     input logic [2:0] id, input logic valid, input logic tmo);
    vec_t v;
    v.en = en; v.req = req; v.gnt = gnt; v.id = id; v.valid = valid; v.tmo = tmo;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] gnt, input logic [2:0] id,
                     input logic valid, input logic tmo);
    checks++;
    if (bus.gnt !== gnt || bus.gnt_id !== id || bus.gnt_valid !== valid || bus.timeout !== tmo) begin
      errors++;
      $display("FAIL %s: got gnt=%h id=%0d valid=%b timeout=%b, expected gnt=%h id=%0d valid=%b timeout=%b",
               name, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout, gnt, id, valid, tmo);
    end
  endtask

  task automatic cycle(input logic en, input logic [7:0] req);
    @(negedge clk);
    bus.arb_en = en;
    bus.req    = req;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.arb_en = 1'b0;
    bus.req    = 8'hFF;
    rst_n      = 1'b1;

    // Idle with everything requested but arbitration disabled
    for (int i = 0; i < 5; i++) add(1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);
    // Priority resolution 0100_1010: index 6 first, then index 3 after a 2-edge gap
    add(1'b1, 8'h4A, 8'h40, 3'd6, 1'b1, 1'b0);
    add(1'b1, 8'h0A, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 8'h0A, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 8'h0A, 8'h08, 3'd3, 1'b1, 1'b0);
    add(1'b1, 8'h0A, 8'h08, 3'd3, 1'b1, 1'b0);
    add(1'b1, 8'h8A, 8'h08, 3'd3, 1'b1, 1'b0);  // higher request does not pre-empt
    add(1'b0, 8'h0A, 8'h08, 3'd3, 1'b1, 1'b0);  // arb_en low does not drop grant
    add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b0, 8'h02, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b0, 8'h02, 8'h00, 3'd0, 1'b0, 1'b0);  // arb_en low blocks decision
    // No pre-emption on index 1, then index 7 after the gap
    add(1'b1, 8'h02, 8'h02, 3'd1, 1'b1, 1'b0);
    add(1'b1, 8'h82, 8'h02, 3'd1, 1'b1, 1'b0);
    add(1'b1, 8'h82, 8'h02, 3'd1, 1'b1, 1'b0);
    add(1'b1, 8'h82, 8'h02, 3'd1, 1'b1, 1'b0);
    add(1'b1, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0);
    // Simultaneous 1010_0000 -> index 7
    add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 8'hA0, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 8'hA0, 8'h80, 3'd7, 1'b1, 1'b0);
    // Lowest index alone
    add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
    add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
`ifdef ARB_TIMEOUT_EN
    // Hold limit 4: index 7 evicted, masked once, then re-granted when alone
    for (int i = 0; i < 4; i++) add(1'b1, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0);
    add(1'b1, 8'h81, 8'h00, 3'd0, 1'b0, 1'b1);
    add(1'b1, 8'h81, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0);
    add(1'b1, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0);
    add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
`endif

    // Reset state, forced asynchronously and held across edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async", 8'h00, 3'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].en, vecs[i].req);
      chk($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].valid, vecs[i].tmo);
    end

    // Async reset mid-grant, then first arbitration right after release
    cycle(1'b1, 8'h10);
    chk("grant_idx4", 8'h10, 3'd4, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_grant", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_arb_after_reset", 8'h10, 3'd4, 1'b1, 1'b0);
    cycle(1'b1, 8'h00);
    chk("release_after_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'h00);

`ifndef ARB_TIMEOUT_EN
    // Without the watchdog a grant is held indefinitely
    cycle(1'b1, 8'h80);
    chk("long_hold_start", 8'h80, 3'd7, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 8'h80);
      chk($sformatf("long_hold%0d", i), 8'h80, 3'd7, 1'b1, 1'b0);
    end
    cycle(1'b1, 8'h00);
    chk("long_hold_release", 8'h00, 3'd0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
